// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Resolves load-use, branch, MDU and data-memory wait hazards.
module hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             bubble_mem_wb,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        MDU_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q;

    logic mem_stall, mdu_busy, load_use, wait_hit;
    logic s_pc, s_ifid, s_idex, s_exmem;
    logic f_ifid, f_idex, b_exmem, b_memwb;

    assign mem_stall = mem_req && !dmem_ready;
    assign mdu_busy  = ex_mdu_start && !mdu_done;
    assign wait_hit  = (wait_q == WC_W'(WAIT_TIMEOUT));

    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_use_rs2 && (id_ex_rd == id_rs2)));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        s_pc    = 1'b0;
        s_ifid  = 1'b0;
        s_idex  = 1'b0;
        s_exmem = 1'b0;
        f_ifid  = 1'b0;
        f_idex  = 1'b0;
        b_exmem = 1'b0;
        b_memwb = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    {s_pc, s_ifid, s_idex, s_exmem} = 4'hf;
                    b_memwb = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WC_W'(1);
                end else if (mdu_busy) begin
                    {s_pc, s_ifid, s_idex} = 3'b111;
                    b_exmem = 1'b1;
                    state_d = MDU_WAIT;
                    wait_d  = WC_W'(1);
                end else if (ex_branch_taken) begin
                    f_ifid = 1'b1;
                    f_idex = 1'b1;
                end else if (load_use) begin
                    s_pc   = 1'b1;
                    s_ifid = 1'b1;
                    f_idex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_hit) begin
                    state_d = RUN;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    {s_pc, s_ifid, s_idex, s_exmem} = 4'hf;
                    b_memwb = 1'b1;
                    wait_d  = wait_q + 1'b1;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_hit) begin
                    state_d = RUN;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    {s_pc, s_ifid, s_idex} = 3'b111;
                    b_exmem = 1'b1;
                    s_exmem = mem_stall;
                    b_memwb = mem_stall;
                    wait_d  = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Controls are forced low while reset is held.
    assign stall_pc      = rst_n & s_pc;
    assign stall_if_id   = rst_n & s_ifid;
    assign stall_id_ex   = rst_n & s_idex;
    assign stall_ex_mem  = rst_n & s_exmem;
    assign flush_if_id   = rst_n & f_ifid;
    assign flush_id_ex   = rst_n & f_idex;
    assign bubble_ex_mem = rst_n & b_exmem;
    assign bubble_mem_wb = rst_n & b_memwb;
    assign timeout_err   = err_q;
    assign stall_cnt     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (stall_pc && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Expected outputs are queued per driven cycle and popped at sample time.
module tb_hazard_ctrl;

    localparam int TO = 6;
    localparam int CW = 4;

    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] MEMS = 8'b1111_0001;
    localparam logic [7:0] MDUS = 8'b1110_0010;
    localparam logic [7:0] MDMS = 8'b1111_0011;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] LU   = 8'b1100_0100;

    logic clk, rst_n;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic id_use_rs1, id_use_rs2, id_ex_memread;
    logic ex_branch_taken, ex_mdu_start, mdu_done;
    logic mem_req, dmem_ready;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic timeout_err;
    logic [CW-1:0] stall_cnt;

    logic [7:0]  ctl_w;
    logic [12:0] obs;
    logic [12:0] sb[$];
    logic [CW-1:0] exp_cnt;
    logic exp_err;
    int n_pass, n_tot;

    assign ctl_w = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                    flush_if_id, flush_id_ex, bubble_ex_mem, bubble_mem_wb};
    assign obs = {ctl_w, timeout_err, stall_cnt};

    hazard_ctrl #(.WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_ex_memread = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Queue this cycle's expectation; count model advances on stall_pc.
    task automatic push_exp(input logic [7:0] ctl);
        sb.push_back({ctl, exp_err, exp_cnt});
        if (ctl[7] && (exp_cnt != '1))
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        idle();
        mem_req = 1'b1;
        id_ex_memread = 1'b1; id_ex_rd = 5'd3;
        id_use_rs1 = 1'b1; id_rs1 = 5'd3;
        repeat (2) @(negedge clk);
        push_exp(NONE);
        #2;
        e = sb.pop_front();
        n_tot++;
        if (obs !== e) $display("FAIL reset got %b exp %b", obs, e);
        else n_pass++;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [12:0] e;
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin id_ex_memread = 1; id_ex_rd = 5; id_use_rs2 = 1;
                         id_rs2 = 5; push_exp(LU); end
                1: begin id_use_rs2 = 1; id_rs2 = 5; push_exp(NONE); end
                2: begin id_ex_memread = 1; id_ex_rd = 0; id_use_rs2 = 1;
                         id_rs2 = 0; push_exp(NONE); end
                3: begin id_ex_memread = 1; id_ex_rd = 7; id_use_rs1 = 1;
                         id_rs1 = 7; push_exp(LU); end
                default: begin id_ex_memread = 1; id_ex_rd = 7; id_rs1 = 7;
                         id_use_rs2 = 1; id_rs2 = 3; push_exp(NONE); end
            endcase
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL load_use[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [12:0] e;
        for (int i = 0; i < 2; i++) begin
            idle();
            if (i == 0) begin
                ex_branch_taken = 1; id_ex_memread = 1; id_ex_rd = 9;
                id_use_rs1 = 1; id_rs1 = 9;
            end
            push_exp(i == 0 ? BR : NONE);
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL branch[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wait();
        logic [12:0] e;
        for (int i = 0; i < 6; i++) begin
            idle();
            mem_req = (i < 4);
            dmem_ready = (i == 3);
            ex_branch_taken = (i >= 1 && i <= 4);
            push_exp(i < 3 ? MEMS : (i == 4 ? BR : NONE));
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL mem_wait[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_mdu();
        logic [12:0] e;
        for (int i = 0; i < 7; i++) begin
            idle();
            ex_mdu_start = (i < 6);
            mdu_done = (i == 5);
            mem_req = (i == 2);
            push_exp(i == 2 ? MDMS : (i < 5 ? MDUS : NONE));
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL mdu[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        for (int i = 0; i < 6; i++) begin
            idle();
            mem_req = (i < 3);
            dmem_ready = (i == 2);
            ex_mdu_start = (i < 5);
            mdu_done = (i == 4);
            push_exp(i < 2 ? MEMS : (i == 3 ? MDUS : NONE));
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL back_to_back[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [12:0] e;
        for (int i = 0; i < 17; i++) begin
            idle();
            ex_mdu_start = (i <= 6);
            mem_req = (i >= 9 && i <= 15);
            if (i < 6) push_exp(MDUS);
            else if (i >= 9 && i < 15) push_exp(MEMS);
            else push_exp(NONE);
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL timeout[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            if (i == 6) exp_err = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] e;
        for (int i = 0; i < 2; i++) begin
            idle();
            mem_req = 1'b1;
            push_exp(MEMS);
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL areset_pre[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            if (i == 0) @(negedge clk);
        end
        rst_n = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
        #1;
        push_exp(NONE);
        e = sb.pop_front();
        n_tot++;
        if (obs !== e) $display("FAIL areset_mid got %b exp %b", obs, e);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            ex_mdu_start = (i < 2);
            mdu_done = (i == 1);
            push_exp(i == 0 ? MDUS : NONE);
            #2;
            e = sb.pop_front();
            n_tot++;
            if (obs !== e) $display("FAIL areset_post[%0d] got %b exp %b", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot = 0;
        exp_cnt = '0;
        exp_err = 1'b0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mdu();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage CPU. It covers the producer-side hazards that operand forwarding cannot resolve: load-use dependencies, taken-branch redirects, multi-cycle MDU operations and data-memory wait states. It drives per-stage stall (hold) and flush (bubble) controls to the pipeline registers. It also keeps a stall-cycle performance counter and a sticky timeout error.

Parameters:
WAIT_TIMEOUT, 64, max cycles spent in MEM_WAIT or MDU_WAIT before forced release (>=2)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_ex_memread  in  1  instruction in EX is a load
id_ex_rd  in  5  destination of instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch/jump
ex_mdu_start  in  1  EX holds a mul/div op
mdu_done  in  1  MDU result valid this cycle
mem_req  in  1  MEM stage holds a load/store
dmem_ready  in  1  data memory completes access this cycle
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
flush_if_id  out  1  load NOP into IF/ID
flush_id_ex  out  1  load NOP into ID/EX
bubble_ex_mem  out  1  load NOP into EX/MEM
bubble_mem_wb  out  1  load NOP into MEM/WB
timeout_err  out  1  sticky: a wait hit WAIT_TIMEOUT
stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, wait_cnt=0, stall_cnt=0, timeout_err=0. All control outputs read 0 while in reset. Reset mid-wait aborts the wait immediately.
- FSM states: RUN, MEM_WAIT, MDU_WAIT. State and counters are registered; control outputs are combinational from state and inputs (same-cycle effect).
- Priority in RUN, highest first:
  1. mem stall (mem_req && !dmem_ready)
  2. MDU busy (ex_mdu_start && !mdu_done)
  3. branch flush
  4. load-use
- Mem stall in RUN: all four stall_* =1, bubble_mem_wb=1. Next state MEM_WAIT, wait_cnt<=1.
- MEM_WAIT:
  - while !dmem_ready: same outputs as mem stall entry; wait_cnt increments.
  - dmem_ready=1: all outputs 0 that cycle; next state RUN.
- MDU busy in RUN: stall_pc, stall_if_id, stall_id_ex =1; bubble_ex_mem=1. Next state MDU_WAIT, wait_cnt<=1.
- MDU_WAIT:
  - while !mdu_done: same outputs as MDU busy entry.
  - mdu_done=1: outputs 0; next state RUN.
  - a mem stall arising while in MDU_WAIT additionally asserts stall_ex_mem and bubble_mem_wb; state stays MDU_WAIT.
- Timeout: in either wait state, if wait_cnt==WAIT_TIMEOUT and the completion input is still 0:
  - release all stalls that cycle;
  - set timeout_err=1 (cleared only by reset);
  - next state RUN, wait_cnt=0.
- Branch (RUN, no higher-priority condition): flush_if_id=1, flush_id_ex=1, no stalls, load-use suppressed. A branch seen during any stall/wait is not flushed; EX is held, so the branch is re-evaluated after release.
- Load-use: condition is
  id_ex_memread && id_ex_rd!=0 && ((id_use_rs1 && id_ex_rd==id_rs1) || (id_use_rs2 && id_ex_rd==id_rs2))
  - outputs stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly one cycle;
  - the bubble clears id_ex_memread, so the stall does not repeat;
  - stays in RUN.
- Simultaneous mem stall and MDU start: enter MEM_WAIT first. EX is held, so ex_mdu_start persists, and MDU_WAIT is entered in the first RUN cycle after memory release.
- stall_cnt increments on every cycle with stall_pc=1 and saturates at all-ones with no wrap.

Test Plan:
- Load-use: EX=load x5 (id_ex_memread=1, id_ex_rd=5), ID reads rs2=5 -> exactly 1 cycle of stall_pc=1, stall_if_id=1, flush_id_ex=1, then all 0; stall_cnt=1. Repeat with rd=0 -> no stall.
- Taken branch in RUN plus a simultaneous load-use match -> flush_if_id=1, flush_id_ex=1, stall_pc=0 for 1 cycle; stall_cnt unchanged.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles then high -> all four stall_* =1 and bubble_mem_wb=1 for 3 cycles, all 0 on the ready cycle; state returns to RUN; stall_cnt=3.
- MDU: ex_mdu_start=1, mdu_done after 5 cycles -> stall_pc, stall_if_id, stall_id_ex and bubble_ex_mem high for 5 cycles, low on the done cycle.
- Timeout (WAIT_TIMEOUT=4): mdu_done never asserts -> stalls release when wait_cnt reaches 4; timeout_err=1 and stays 1 until reset.
- Async reset asserted mid-MEM_WAIT (between clock edges) -> all outputs 0 immediately; stall_cnt=0, timeout_err=0; RUN after release.
